// File: rtl/inst_fetch_queue_if.sv
// Fetch-queue bundle: imem request/response, issue handshake,
// redirect and drain status.
interface inst_fetch_queue_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            iq_valid;
  logic            iq_ready;
  logic [XLEN-1:0] iq_instr;
  logic [XLEN-1:0] iq_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            fetch_done;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    output iq_valid,
    input  iq_ready,
    output iq_instr,
    output iq_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_done
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    input  iq_valid,
    output iq_ready,
    input  iq_instr,
    input  iq_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_done
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Tomasulo front end: sequential fetch from a synchronous imem into
// an in-order instruction FIFO, with halt detection and redirect.
module inst_fetch_queue #(
  parameter int              DEPTH      = 8,
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h0000_0073)
) (
  input logic              clk,
  input logic              reset,
  inst_fetch_queue_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {
    FETCH,
    HALTED
  } state_t;

  state_t          state;
  state_t          state_nxt;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] resp_pc;
  logic            pending;
  logic            squash;
  logic            done_q;
  logic [CW-1:0]   count;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;

  logic [XLEN-1:0] instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];

  logic [CW-1:0]   credit;
  logic            req;
  logic            resp_ok;
  logic            is_halt;
  logic            enq;
  logic            deq;
  logic            nonempty;
  logic            done_cond;

  // Credit counts the in-flight response so the FIFO can never overflow.
  assign credit    = count + CW'(pending);
  assign nonempty  = (count != '0);
  assign deq       = bus.iq_valid && bus.iq_ready;
  assign done_cond = (state == HALTED) && !nonempty && !pending;

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    resp_ok   = 1'b0;
    is_halt   = 1'b0;
    enq       = 1'b0;

    req = (state == FETCH)
       && (credit < CW'(DEPTH))
       && !bus.redirect_valid
       && !reset;

    resp_ok = pending
           && !squash
           && !bus.redirect_valid
           && (state == FETCH);

    is_halt = resp_ok && (bus.imem_rdata == HALT_INSTR);
    enq     = resp_ok && !is_halt;

    unique case (1'b1)
      bus.redirect_valid: state_nxt = FETCH;
      is_halt:            state_nxt = HALTED;
      default:            state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      resp_pc <= '0;
      pending <= 1'b0;
      squash  <= 1'b0;
      done_q  <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else if (bus.redirect_valid) begin
      pc      <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      pending <= 1'b0;
      squash  <= 1'b0;
      done_q  <= 1'b0;
      count   <= '0;
      head    <= '0;
      tail    <= '0;
    end else begin
      pending <= req;
      if (req) begin
        pc      <= pc + XLEN'(4);
        resp_pc <= pc;
      end
      // A request racing the halt response is already doomed.
      if (is_halt && req) begin
        squash <= 1'b1;
      end else if (pending) begin
        squash <= 1'b0;
      end
      if (enq) begin
        tail <= tail + AW'(1);
      end
      if (deq) begin
        head <= head + AW'(1);
      end
      count  <= count + CW'(enq) - CW'(deq);
      done_q <= done_cond;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[tail] <= bus.imem_rdata;
      pc_mem[tail]    <= resp_pc;
    end
  end

  assign bus.imem_req   = req;
  assign bus.imem_addr  = pc;
  assign bus.iq_valid   = nonempty && !bus.redirect_valid;
  assign bus.iq_instr   = nonempty ? instr_mem[head] : '0;
  assign bus.iq_pc      = nonempty ? pc_mem[head] : '0;
  assign bus.fetch_done = done_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue: expected PCs are queued per
// scenario and popped on every issue handshake.
module tb_inst_fetch_queue;

  localparam int          XLEN  = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] HALT  = 32'h0000_0073;
  localparam logic [31:0] NONE  = 32'hFFFF_FFF0;

  logic clk = 1'b0;
  logic reset = 1'b1;

  always #5 clk = ~clk;

  inst_fetch_queue_if #(.XLEN(XLEN)) bus();

  inst_fetch_queue #(
    .DEPTH(DEPTH),
    .XLEN(XLEN),
    .HALT_INSTR(HALT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          nreq = 0;
  int          npop = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_addr = '0;
  logic [31:0] halt_addr = NONE;

  function automatic logic [31:0] instr_at(logic [31:0] a);
    if (a == halt_addr) return HALT;
    return {a[24:0], 7'h13};
  endfunction

  always @(posedge clk) begin
    bus.imem_rdata <= bus.imem_req ? instr_at(bus.imem_addr)
                                   : 32'hFFFF_FFFF;
  end

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push_seq(logic [31:0] start, int n);
    sb.delete();
    for (int i = 0; i < n; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic mon();
    logic [31:0] p;
    if (bus.imem_req) begin
      chk("imem_addr", bus.imem_addr, exp_addr);
      exp_addr = exp_addr + 32'd4;
      nreq++;
    end
    if (bus.iq_valid) chk("no_halt_out", 32'(bus.iq_instr == HALT), 0);
    if (bus.iq_valid && bus.iq_ready) begin
      npop++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        p = sb.pop_front();
        chk("iq_pc", bus.iq_pc, p);
        chk("iq_instr", bus.iq_instr, instr_at(p));
      end
    end
  endtask

  task automatic step();
    #1;
    mon();
    @(negedge clk);
  endtask

  task automatic redirect_to(logic [31:0] pc);
    exp_addr = {pc[31:2], 2'b00};
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = pc;
    step();
    bus.redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bus.iq_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus.imem_req), 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_valid", 32'(bus.iq_valid), 0);
    chk("rst_instr", bus.iq_instr, 0);
    chk("rst_pc", bus.iq_pc, 0);
    chk("rst_done", 32'(bus.fetch_done), 0);

    // stream
    reset = 1'b0;
    bus.iq_ready = 1'b1;
    push_seq(32'h0, 200);
    step();
    chk("first_valid_c1", 32'(bus.iq_valid), 0);
    step();
    chk("first_valid_c2", 32'(bus.iq_valid), 1);
    chk("first_pc", bus.iq_pc, 0);
    repeat (12) step();

    // backpressure
    bus.iq_ready = 1'b0;
    repeat (20) step();
    #1;
    chk("bp_req_low", 32'(bus.imem_req), 0);
    chk("bp_held", 32'(nreq - npop), 8);
    chk("bp_valid", 32'(bus.iq_valid), 1);

    // full push/pop
    bus.iq_ready = 1'b1;
    repeat (16) begin
      chk("full_valid", 32'(bus.iq_valid), 1);
      step();
    end

    // redirect with 3 queued and 1 pending
    bus.iq_ready = 1'b0;
    push_seq(32'h100, 50);
    redirect_to(32'h100);
    repeat (4) step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h43;
    #1;
    chk("rd_valid_low", 32'(bus.iq_valid), 0);
    chk("rd_req_low", 32'(bus.imem_req), 0);
    push_seq(32'h40, 50);
    exp_addr = 32'h40;
    step();
    bus.redirect_valid = 1'b0;
    #1;
    chk("rd_empty", 32'(bus.iq_valid), 0);
    bus.iq_ready = 1'b1;
    step();
    step();
    chk("rd_first_pc", bus.iq_pc, 32'h40);
    repeat (10) step();

    // halt at 0x10
    halt_addr = 32'h10;
    push_seq(32'h0, 4);
    redirect_to(32'h0);
    for (int i = 0; i < 40 && sb.size() != 0; i++) step();
    chk("halt_drained", 32'(sb.size()), 0);
    for (int i = 0; i < 6 && !bus.fetch_done; i++) step();
    chk("halt_done", 32'(bus.fetch_done), 1);
    repeat (5) begin
      step();
      chk("done_held", 32'(bus.fetch_done), 1);
      chk("halt_no_req", 32'(bus.imem_req), 0);
    end

    // redirect clears done, then reset mid-operation
    halt_addr = NONE;
    bus.iq_ready = 1'b0;
    push_seq(32'h200, 50);
    redirect_to(32'h200);
    #1;
    chk("rd_done_clr", 32'(bus.fetch_done), 0);
    repeat (6) step();
    chk("pre_rst_valid", 32'(bus.iq_valid), 1);
    chk("pre_rst_pc", bus.iq_pc, 32'h200);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_valid", 32'(bus.iq_valid), 0);
    chk("arst_req", 32'(bus.imem_req), 0);
    chk("arst_done", 32'(bus.fetch_done), 0);
    chk("arst_pc", bus.iq_pc, 0);
    @(negedge clk);
    reset = 1'b0;
    push_seq(32'h0, 50);
    exp_addr = 32'h0;
    bus.iq_ready = 1'b1;
    step();
    step();
    chk("rst_restart_valid", 32'(bus.iq_valid), 1);
    chk("rst_restart_pc", bus.iq_pc, 0);
    repeat (10) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
